cam_bt656_decoder: RTL and testbench

CAM_BT656_DECODER -- requirements
Module: cam_bt656_decoder

---
 rtl/cam_bt656_decoder.sv | 164 ++++++++++++++++
 tb/tb_cam_bt656_decoder.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_bt656_decoder.sv
// BT.656 embedded-sync decoder.
// Finds FF 00 00 XY timing codes in the camera byte stream and turns them into
// hsync/vsync/field strobes aligned with a 4-cycle delayed copy of the stream.
// Bytes pass through a 4-deep delay line. This gives the decoder enough
// lookahead to strip a code's preamble from hsync once the XY byte is accepted.
// Optional feature: define CAM_BT656_ECC_EN to check the XY protection bits.
// Ports:
//   s_cam_clk_dft  camera pixel clock
//   rstn_i         async active-low reset
//   cfg_en_i       decoder enable (other clock domain, synchronised here)
//   cam_data_i     raw byte stream with embedded sync codes
//   cam_data_o     cam_data_i delayed by 4 cycles
//   cam_hsync_o    high on active-video output bytes
//   cam_vsync_o    V flag of last accepted code
//   cam_field_o    F flag of last accepted code
//   line_len_o     active bytes in the last completed line
//   seq_err_o      one-cycle timing-sequence error pulse
//   ecc_err_o      one-cycle protection-bit error pulse
module cam_bt656_decoder (
  input  logic        s_cam_clk_dft,
  input  logic        rstn_i,
  input  logic        cfg_en_i,
  input  logic [7:0]  cam_data_i,
  output logic [7:0]  cam_data_o,
  output logic        cam_hsync_o,
  output logic        cam_vsync_o,
  output logic        cam_field_o,
  output logic [15:0] line_len_o,
  output logic        seq_err_o,
  output logic        ecc_err_o
);

  localparam int unsigned DW  = 8;
  localparam int unsigned CW  = 16;
  localparam int unsigned DLY = 4;
  localparam int unsigned PRE = 3;
  localparam logic [CW-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {SRCH, FF1, Z1, Z2} state_t;

  state_t                  state, state_nxt;
  logic [1:0]              en_sync;
  logic                    en_s;
  logic [DLY-1:0][DW-1:0]  dly;
  logic [DLY-1:0]          tag;
  logic                    line_open;
  logic [CW-1:0]           cnt;

  logic is_ff_c, is_00_c, xy_c, ecc_ok_c;
  logic acc_c, sav_c, eav_c, cont_c, bad_bit7_c, bad_ecc_c;
  logic f_c, v_c, h_c;
`ifdef CAM_BT656_ECC_EN
  logic [3:0] p_exp_c;
`endif

  assign en_s = en_sync[1];

  // Enable synchroniser
  always_ff @(posedge s_cam_clk_dft or negedge rstn_i) begin
    if (!rstn_i) en_sync <= '0;
    else         en_sync <= {en_sync[0], cfg_en_i};
  end

  // Sync-code detector state register
  always_ff @(posedge s_cam_clk_dft or negedge rstn_i) begin
    if (!rstn_i) state <= SRCH;
    else         state <= state_nxt;
  end

  // Next state and code classification of the current input byte
  always_comb begin
    state_nxt  = SRCH;
    xy_c       = 1'b0;
    ecc_ok_c   = 1'b1;
    is_ff_c    = (cam_data_i == 8'hFF);
    is_00_c    = (cam_data_i == 8'h00);
    f_c        = cam_data_i[6];
    v_c        = cam_data_i[5];
    h_c        = cam_data_i[4];
`ifdef CAM_BT656_ECC_EN
    p_exp_c    = {v_c ^ h_c, f_c ^ h_c, f_c ^ v_c, f_c ^ v_c ^ h_c};
`endif
    if (en_s) begin
      case (state)
        SRCH:    if (is_ff_c) state_nxt = FF1;
        FF1:     if (is_00_c) state_nxt = Z1;
                 else if (is_ff_c) state_nxt = FF1;
        Z1:      if (is_00_c) state_nxt = Z2;
                 else if (is_ff_c) state_nxt = FF1;
        Z2:      xy_c = 1'b1;
        default: state_nxt = SRCH;
      endcase
    end
`ifdef CAM_BT656_ECC_EN
    ecc_ok_c   = (cam_data_i[3:0] == p_exp_c);
`endif
    bad_bit7_c = xy_c & ~cam_data_i[7];
    acc_c      = xy_c & cam_data_i[7] & ecc_ok_c;
    bad_ecc_c  = xy_c & cam_data_i[7] & ~ecc_ok_c;
    sav_c      = acc_c & ~h_c;
    eav_c      = acc_c & h_c;
    // SAV inside an open line restarts it without a gap in hsync
    cont_c     = sav_c & ~v_c & line_open;
  end

  // Byte delay line with per-byte active tag
  always_ff @(posedge s_cam_clk_dft or negedge rstn_i) begin
    if (!rstn_i) begin
      dly <= '0;
      tag <= '0;
    end else begin
      dly <= {dly[DLY-2:0], cam_data_i};
      if (!en_s)
        tag <= '0;
      else if (acc_c && !cont_c)
        tag <= '0;  // preamble sits in stages 0..2, XY is entering: none active
      else
        tag <= {tag[DLY-2:0], line_open};
    end
  end

  assign cam_data_o  = dly[DLY-1];
  assign cam_hsync_o = tag[DLY-1];

  // Line tracking, flags and error pulses
  always_ff @(posedge s_cam_clk_dft or negedge rstn_i) begin
    if (!rstn_i) begin
      line_open   <= 1'b0;
      cnt         <= '0;
      cam_vsync_o <= 1'b0;
      cam_field_o <= 1'b0;
      line_len_o  <= '0;
      seq_err_o   <= 1'b0;
      ecc_err_o   <= 1'b0;
    end else begin
      seq_err_o <= bad_bit7_c | (sav_c & line_open) | (eav_c & ~line_open);
      ecc_err_o <= bad_ecc_c;
      if (!en_s) begin
        line_open   <= 1'b0;
        cnt         <= '0;
        cam_vsync_o <= 1'b0;
        cam_field_o <= 1'b0;
      end else if (acc_c) begin
        cam_vsync_o <= v_c;
        cam_field_o <= f_c;
        if (sav_c) begin
          cnt       <= '0;
          line_open <= ~v_c;
        end else begin
          line_open <= 1'b0;
          // the code's own preamble was counted while the line was open
          if (line_open) begin
            if (cnt == CNT_MAX)      line_len_o <= CNT_MAX;
            else if (cnt >= CW'(PRE)) line_len_o <= cnt - CW'(PRE);
            else                     line_len_o <= '0;
          end
        end
      end else if (line_open && cnt != CNT_MAX) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_cam_bt656_decoder.sv
// Scoreboard bench for cam_bt656_decoder: directed byte streams, expected
// active bytes queued at stimulus time, popped by a negedge monitor.
module tb_cam_bt656_decoder;

  logic        clk = 1'b0;
  logic        rstn;
  logic        cfg_en;
  logic [7:0]  din;
  logic [7:0]  cam_data_o;
  logic        cam_hsync_o, cam_vsync_o, cam_field_o;
  logic [15:0] line_len_o;
  logic        seq_err_o, ecc_err_o;

  cam_bt656_decoder dut (
    .s_cam_clk_dft (clk),
    .rstn_i        (rstn),
    .cfg_en_i      (cfg_en),
    .cam_data_i    (din),
    .cam_data_o    (cam_data_o),
    .cam_hsync_o   (cam_hsync_o),
    .cam_vsync_o   (cam_vsync_o),
    .cam_field_o   (cam_field_o),
    .line_len_o    (line_len_o),
    .seq_err_o     (seq_err_o),
    .ecc_err_o     (ecc_err_o)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_err = 0;
  int         seq_seen = 0;
  int         ecc_seen = 0;
  int         exp_seq = 0;
  int         exp_ecc = 0;
  bit         bypass = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] hist[4];
  logic [7:0] e;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference record of the last four sampled input bytes
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 4; i++) hist[i] <= 8'h00;
    end else begin
      hist[0] <= din;
      for (int i = 1; i < 4; i++) hist[i] <= hist[i-1];
    end
  end

  // Monitor: delay check, error pulse counting, active-byte scoreboard
  always @(negedge clk) begin
    chk("data_delay", int'(cam_data_o), int'(hist[3]));
    if (seq_err_o) seq_seen++;
    if (ecc_err_o) ecc_seen++;
    if (cam_hsync_o && !bypass) begin
      if (exp_q.size() == 0) begin
        chk("hsync_unexpected", int'(cam_data_o), -1);
      end else begin
        e = exp_q.pop_front();
        chk("hsync_data", int'(cam_data_o), int'(e));
      end
    end
  end

  task automatic send(input logic [7:0] b, input bit act);
    din = b;
    if (act) exp_q.push_back(b);
    @(posedge clk);
    #1;
  endtask

  task automatic code(input logic [7:0] xy, input bit act);
    send(8'hFF, act);
    send(8'h00, act);
    send(8'h00, act);
    send(xy, act);
  endtask

  task automatic data(input logic [7:0] first, input int n, input bit act);
    for (int i = 0; i < n; i++) send(first + 8'(i), act);
  endtask

  task automatic filler(input int n);
    for (int i = 0; i < n; i++) send(8'h10, 1'b0);
  endtask

  task automatic drain(input string name);
    filler(6);
    chk(name, exp_q.size(), 0);
    chk({name, "_seq"}, seq_seen, exp_seq);
    chk({name, "_ecc"}, ecc_seen, exp_ecc);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_data"},  int'(cam_data_o), 0);
    chk({name, "_hsync"}, int'(cam_hsync_o), 0);
    chk({name, "_vsync"}, int'(cam_vsync_o), 0);
    chk({name, "_field"}, int'(cam_field_o), 0);
    chk({name, "_len"},   int'(line_len_o), 0);
    chk({name, "_seq"},   int'(seq_err_o), 0);
    chk({name, "_ecc"},   int'(ecc_err_o), 0);
  endtask

  initial begin
    rstn   = 1'b0;
    cfg_en = 1'b0;
    din    = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rstn   = 1'b1;
    cfg_en = 1'b1;
    filler(4);

    // Normal line of 10 active bytes
    code(8'h80, 1'b0);
    data(8'h11, 10, 1'b1);
    code(8'h9D, 1'b0);
    drain("line10");
    chk("line10_len", int'(line_len_o), 10);
    chk("line10_vsync", int'(cam_vsync_o), 0);

    // Vertical blanking: SAV V=1 opens nothing, EAV without line is flagged
    code(8'hAB, 1'b0);
    data(8'h21, 5, 1'b0);
    code(8'hB6, 1'b0);
    exp_seq++;
    drain("vblank");
    chk("vblank_vsync", int'(cam_vsync_o), 1);
    chk("vblank_len", int'(line_len_o), 10);

    // SAV with wrong protection bits
`ifdef CAM_BT656_ECC_EN
    code(8'h81, 1'b0);
    data(8'h31, 2, 1'b0);
    code(8'h9D, 1'b0);
    exp_ecc++;
    exp_seq++;
    drain("badp");
    chk("badp_len", int'(line_len_o), 10);
`else
    code(8'h81, 1'b0);
    data(8'h31, 2, 1'b1);
    code(8'h9D, 1'b0);
    drain("badp");
    chk("badp_len", int'(line_len_o), 2);
`endif
    chk("badp_vsync", int'(cam_vsync_o), 0);

    // Repeated FF in the preamble
    send(8'hFF, 1'b0);
    code(8'h80, 1'b0);
    data(8'h41, 3, 1'b1);
    code(8'h9D, 1'b0);
    drain("ffff");
    chk("ffff_len", int'(line_len_o), 3);

    // Broken preamble followed by a good one
    send(8'hFF, 1'b0);
    send(8'h00, 1'b0);
    code(8'h80, 1'b0);
    data(8'h51, 1, 1'b1);
    code(8'h9D, 1'b0);
    drain("restart");
    chk("restart_len", int'(line_len_o), 1);

    // XY with bit7 clear
    code(8'h7F, 1'b0);
    exp_seq++;
    drain("bit7");
    chk("bit7_len", int'(line_len_o), 1);

    // EAV with F=1 and no open line
    code(8'hDA, 1'b0);
    exp_seq++;
    drain("field");
    chk("field_f", int'(cam_field_o), 1);

    // Second SAV 3 bytes into a line: hsync stays up, count restarts
    code(8'h80, 1'b0);
    data(8'h61, 3, 1'b1);
    code(8'h80, 1'b1);
    data(8'h64, 2, 1'b1);
    code(8'h9D, 1'b0);
    exp_seq++;
    drain("dblsav");
    chk("dblsav_len", int'(line_len_o), 2);
    chk("dblsav_field", int'(cam_field_o), 0);

    // Enable dropped mid-line; the line is not rejoined afterwards
    bypass = 1'b1;
    code(8'h80, 1'b0);
    data(8'h71, 4, 1'b0);
    chk("enoff_pre_hsync", int'(cam_hsync_o), 1);
    chk("enoff_pre_data", int'(cam_data_o), 8'h71);
    cfg_en = 1'b0;
    data(8'h75, 3, 1'b0);
    chk("enoff_hsync", int'(cam_hsync_o), 0);
    chk("enoff_vsync", int'(cam_vsync_o), 0);
    filler(3);
    chk("enoff_hsync_late", int'(cam_hsync_o), 0);
    bypass = 1'b0;
    cfg_en = 1'b1;
    filler(3);
    data(8'h78, 3, 1'b0);
    code(8'h9D, 1'b0);
    exp_seq++;
    drain("enon");
    chk("enon_len", int'(line_len_o), 2);

    // Reset in the middle of an open line
    bypass = 1'b1;
    code(8'h80, 1'b0);
    data(8'h81, 4, 1'b0);
    chk("rst_pre_hsync", int'(cam_hsync_o), 1);
    rstn = 1'b0;
    #2;
    chk_all_zero("midreset");
    @(posedge clk);
    #1;
    rstn   = 1'b1;
    bypass = 1'b0;
    filler(4);
    data(8'h91, 4, 1'b0);
    drain("postreset");
    chk("postreset_len", int'(line_len_o), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
